mac_add_normalize: RTL

- Pipelined stage directly downstream of the MAC pre-normalizer.
- Adds the aligned addend mantissa to the Wallace sum/carry pair from the multiplier tree.
- Resolves the sign of the result, converts a negative result to magnitude, and left-normalizes via leading-zero count.
- Passes the normalized mantissa, exponent, sign and sticky to the rounder.

---
 rtl/mac_add_normalize.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/mac_add_normalize.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | mac_add_normalize                                                          |
// | Two-stage MAC adder: addend + Wallace sum/carry, sign resolve, normalize.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mac_add_normalize #(
    parameter int PARM_EXP  = 8,
    parameter int PARM_MANT = 23
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [3*PARM_MANT+5:0]   A_Mant_aligned_i,
    input  logic [2*PARM_MANT+2:0]   Wallace_sum_i,
    input  logic [2*PARM_MANT+2:0]   Wallace_carry_i,
    input  logic [PARM_EXP+1:0]      Exp_aligned_i,
    input  logic                     Sign_aligned_i,
    input  logic                     Sub_Sign_i,
    input  logic                     Mant_sticky_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [3*PARM_MANT+4:0]   Mant_norm_o,
    output logic [PARM_EXP+1:0]      Exp_norm_o,
    output logic                     Sign_o,
    output logic                     Sticky_o,
    output logic                     Zero_o
);

    localparam int c_add_w  = 3*PARM_MANT+6;
    localparam int c_prod_w = 2*PARM_MANT+3;
    localparam int c_m_w    = c_add_w-1;
    localparam int c_e_w    = PARM_EXP+2;
    localparam int c_lz_w   = $clog2(c_add_w);
    localparam int c_pad_w  = c_add_w-c_prod_w;

    logic                 r_s1_valid;
    logic [c_m_w-1:0]     r_s1_m;
    logic [c_e_w-1:0]     r_s1_exp;
    logic                 r_s1_sign;
    logic                 r_s1_zsign;
    logic                 r_s1_sticky;

    logic                 r_s2_valid;
    logic [c_m_w-1:0]     r_s2_mant;
    logic [c_e_w-1:0]     r_s2_exp;
    logic                 r_s2_sign;
    logic                 r_s2_sticky;
    logic                 r_s2_zero;

    logic                 w_s1_adv;
    logic                 w_s2_adv;
    logic                 w_cin;
    logic [c_add_w-1:0]   w_sum;
    logic [c_m_w-1:0]     w_neg;
    logic [c_m_w-1:0]     w_m;
    logic [c_e_w-1:0]     w_exp1;
    logic                 w_sign1;
    logic                 w_sticky1;
    logic [c_lz_w-1:0]    w_lzc;
    logic                 w_zero;
    logic [c_m_w-1:0]     w_mant_sh;
    logic [c_e_w-1:0]     w_exp2;

    assign w_s2_adv   = ~r_s2_valid | out_ready_i;
    assign w_s1_adv   = ~r_s1_valid | w_s2_adv;
    assign in_ready_o = w_s1_adv;

    // Stage 1: three-input add modulo 2^75, then sign/magnitude resolution
    assign w_cin = Sub_Sign_i & ~Mant_sticky_i;
    assign w_sum = A_Mant_aligned_i
                 + {{c_pad_w{1'b0}}, Wallace_sum_i}
                 + {{c_pad_w{1'b0}}, Wallace_carry_i}
                 + {{(c_add_w-1){1'b0}}, w_cin};
    // Only the low bits of the negation are kept, so they depend only on the low bits of the sum
    assign w_neg = ~w_sum[c_m_w-1:0] + {{(c_m_w-1){1'b0}}, 1'b1};

    always_comb begin
        w_m       = w_sum[c_m_w-1:0];
        w_exp1    = Exp_aligned_i;
        w_sign1   = Sign_aligned_i;
        w_sticky1 = Mant_sticky_i;
        if (!Sub_Sign_i && w_sum[c_add_w-1]) begin
            w_m       = w_sum[c_add_w-1:1];
            w_exp1    = Exp_aligned_i + {{(c_e_w-1){1'b0}}, 1'b1};
            w_sticky1 = Mant_sticky_i | w_sum[0];
        end else if (Sub_Sign_i && w_sum[c_add_w-1]) begin
            w_m     = w_neg;
            w_sign1 = ~Sign_aligned_i;
        end
    end

    // Stage 2: leading-zero count; highest set bit wins as the loop ascends
    always_comb begin
        w_lzc = c_lz_w'(c_m_w);
        for (int i = 0; i < c_m_w; i++) begin
            if (r_s1_m[i]) begin
                w_lzc = c_lz_w'(c_m_w-1-i);
            end
        end
    end

    assign w_zero    = (r_s1_m == '0);
    assign w_mant_sh = r_s1_m << w_lzc;
    assign w_exp2    = r_s1_exp - {{(c_e_w-c_lz_w){1'b0}}, w_lzc};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s1_valid  <= 1'b0;
            r_s1_m      <= '0;
            r_s1_exp    <= '0;
            r_s1_sign   <= 1'b0;
            r_s1_zsign  <= 1'b0;
            r_s1_sticky <= 1'b0;
        end else begin
            if (flush_i) begin
                r_s1_valid <= 1'b0;
            end else if (w_s1_adv) begin
                r_s1_valid <= in_valid_i;
            end
            if (w_s1_adv && in_valid_i && !flush_i) begin
                r_s1_m      <= w_m;
                r_s1_exp    <= w_exp1;
                r_s1_sign   <= w_sign1;
                r_s1_zsign  <= Sign_aligned_i & ~Sub_Sign_i;
                r_s1_sticky <= w_sticky1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s2_valid  <= 1'b0;
            r_s2_mant   <= '0;
            r_s2_exp    <= '0;
            r_s2_sign   <= 1'b0;
            r_s2_sticky <= 1'b0;
            r_s2_zero   <= 1'b0;
        end else begin
            if (flush_i) begin
                r_s2_valid <= 1'b0;
            end else if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
            end
            if (w_s2_adv && r_s1_valid && !flush_i) begin
                // Exact cancellation reports +0 unless both operands agreed in sign
                r_s2_mant   <= w_zero ? '0 : w_mant_sh;
                r_s2_exp    <= w_zero ? '0 : w_exp2;
                r_s2_sign   <= w_zero ? r_s1_zsign : r_s1_sign;
                r_s2_sticky <= r_s1_sticky;
                r_s2_zero   <= w_zero;
            end
        end
    end

    assign out_valid_o = r_s2_valid;
    assign Mant_norm_o = r_s2_mant;
    assign Exp_norm_o  = r_s2_exp;
    assign Sign_o      = r_s2_sign;
    assign Sticky_o    = r_s2_sticky;
    assign Zero_o      = r_s2_zero;

endmodule
`default_nettype wire
